// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes and
// datapath mux/ALU select values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_ADDIEX,
    S_ADDIWB,
    S_BRANCH,
    S_JUMP,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that count towards cycle_count (the core is actually working).
  function automatic logic is_active(input state_t s);
    return !(s inside {S_IDLE, S_HALT, S_FAULT});
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory-wait cycles; expired is high once MAX_WAIT
// waits have accumulated without the access completing.
module mc_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (tick && count != LIMIT) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory handshake timeout, sticky halt/fault
// and activity counters. Define MULTICYCLE_CONTROL_BNE_EN to add bne support.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             branch_ne,
  output logic             halt,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state, next_state;
  logic [5:0] op_q;
  logic       in_wait;
  logic       wait_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Opcode is captured in DECODE so later states need not hold IR stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= '0;
    end else if (state == S_DECODE) begin
      op_q <= opcode;
    end
  end

  assign in_wait = state inside {S_FETCH, S_MEMRD, S_MEMWR};

  mc_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait || mem_ready),
    .tick   (in_wait && !mem_ready),
    .expired(wait_expired)
  );

  always_comb begin
    // NOTE: every output and next_state gets a default first so no path
    // through the case statement can infer a latch.
    next_state  = state;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    aluop       = ALU_ADD;
    pcsource    = PC_ALU;
    branch_ne   = 1'b0;
    halt        = 1'b0;
    fault       = 1'b0;

    unique case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        memread  = 1'b1;
        alusrcb  = SRCB_FOUR;
        irwrite  = mem_ready;
        pcwrite  = mem_ready;
        if (mem_ready)         next_state = S_DECODE;
        else if (wait_expired) next_state = S_FAULT;
      end

      S_DECODE: begin
        alusrcb = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:      next_state = S_EXEC;
          OP_ADDI:       next_state = S_ADDIEX;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ:        next_state = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
          OP_BNE:        next_state = S_BRANCH;
`endif
          OP_J:          next_state = S_JUMP;
          OP_HLT:        next_state = S_HALT;
          default:       next_state = S_FAULT;
        endcase
      end

      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        next_state = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready)         next_state = S_MEMWB;
        else if (wait_expired) next_state = S_FAULT;
      end

      S_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        next_state = S_FETCH;
      end

      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready)         next_state = S_FETCH;
        else if (wait_expired) next_state = S_FAULT;
      end

      S_EXEC: begin
        alusrca    = 1'b1;
        aluop      = ALU_FUNCT;
        next_state = S_ALUWB;
      end

      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        next_state = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        next_state = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite   = 1'b1;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALU_SUB;
        pcwritecond = 1'b1;
        pcsource    = PC_ALUOUT;
`ifdef MULTICYCLE_CONTROL_BNE_EN
        branch_ne   = (op_q == OP_BNE);
`else
        branch_ne   = 1'b0;
`endif
        next_state  = S_FETCH;
      end

      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = PC_JUMP;
        next_state = S_FETCH;
      end

      S_HALT:  halt = 1'b1;
      S_FAULT: fault = 1'b1;

      default: next_state = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (is_active(state)) cycle_count <= cycle_count + CNT_W'(1);
      if (irwrite)          instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected
// controls and counters; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int CNT_W    = 32;
  localparam int MAX_WAIT = 4;
  localparam logic [5:0] OPX = 6'h3E;  // junk opcode outside DECODE

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca},
  // alusrcb, aluop, pcsource, {branch_ne,halt,fault}
  localparam logic [18:0] C_ZERO   = '0;
  localparam logic [18:0] C_FW     = {10'b0001000000, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_FR     = {10'b1001010000, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_DEC    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_MEMADR = {10'b0000000001, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_MEMWB  = {10'b0000001010, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_EXEC   = {10'b0000000001, 2'b00, 2'b10, 2'b00, 3'b000};
  localparam logic [18:0] C_ALUWB  = {10'b0000000110, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_ADDIWB = {10'b0000000010, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_BEQ    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 3'b000};
  localparam logic [18:0] C_BNE    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 3'b100};
  localparam logic [18:0] C_JUMP   = {10'b1000000000, 2'b00, 2'b00, 2'b10, 3'b000};
  localparam logic [18:0] C_HALT   = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] C_FAULT  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b001};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       opcode = '0;
  logic             mem_ready = 1'b0;
  logic             pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic             memtoreg, regdst, regwrite, alusrca, branch_ne, halt, fault;
  logic [1:0]       alusrcb, aluop, pcsource;
  logic [CNT_W-1:0] cycle_count, instr_count;
  logic [18:0]      got_ctrl;

  always #5 clk = ~clk;

  multicycle_control #(
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .pcwritecond(pcwritecond),
    .iord       (iord),
    .memread    (memread),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsource   (pcsource),
    .branch_ne  (branch_ne),
    .halt       (halt),
    .fault      (fault),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  assign got_ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                     regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
                     branch_ne, halt, fault};

  typedef struct {
    string       name;
    logic [18:0] ctrl;
    logic [31:0] cyc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cyc = 0;
  int   exp_ins = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  // Counters advance for any state with a datapath control set; the expected
  // instruction count follows the expected irwrite bit.
  task automatic step(input string name, input logic mr, input logic [5:0] op,
                      input logic [18:0] ec);
    exp_t e;
    mem_ready = mr;
    opcode    = op;
    e.name = name;
    e.ctrl = ec;
    e.cyc  = 32'(exp_cyc);
    e.ins  = 32'(exp_ins);
    sb_q.push_back(e);
    if (ec[18:3] != '0) exp_cyc++;
    if (ec[13]) exp_ins++;
    @(posedge clk);
    #1;
  endtask

  // The cycle in which rst is first sampled still shows the old state, so it
  // is left unchecked; the following held-reset cycles must be all zero.
  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = OPX;
    @(posedge clk);
    #1;
    exp_cyc = 0;
    exp_ins = 0;
    repeat (3) step("reset", 1'b0, OPX, C_ZERO);
    rst = 1'b0;
    step("idle", 1'b1, OPX, C_ZERO);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({"ctrl ", e.name}, 32'(got_ctrl), 32'(e.ctrl));
        check({"cycles ", e.name}, cycle_count, e.cyc);
        check({"instrs ", e.name}, instr_count, e.ins);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    do_reset();

    // R-type, addi, sw (one wait), lw (two waits), beq, j back to back
    step("fetch", 1, OPX, C_FR); step("dec_r", 0, 6'h00, C_DEC);
    step("exec", 1, OPX, C_EXEC); step("aluwb", 1, OPX, C_ALUWB);
    step("fetch", 1, OPX, C_FR); step("dec_addi", 0, 6'h08, C_DEC);
    step("addiex", 1, OPX, C_MEMADR); step("addiwb", 1, OPX, C_ADDIWB);
    step("fetch", 1, OPX, C_FR); step("dec_sw", 0, 6'h2B, C_DEC);
    step("memadr_sw", 0, 6'h23, C_MEMADR);
    step("memwr_wait", 0, OPX, C_MEMWR); step("memwr", 1, OPX, C_MEMWR);
    step("fetch", 1, OPX, C_FR); step("dec_lw", 0, 6'h23, C_DEC);
    step("memadr_lw", 0, 6'h2B, C_MEMADR);
    step("memrd_wait", 0, OPX, C_MEMRD); step("memrd_wait", 0, OPX, C_MEMRD);
    step("memrd", 1, OPX, C_MEMRD); step("memwb", 0, OPX, C_MEMWB);
    step("fetch", 1, OPX, C_FR); step("dec_beq", 0, 6'h04, C_DEC);
    step("beq", 0, 6'h05, C_BEQ);
    step("fetch", 1, OPX, C_FR); step("dec_j", 0, 6'h02, C_DEC);
    step("jump", 0, OPX, C_JUMP);

    // mem_ready arriving on the last allowed wait cycle completes the access
    repeat (MAX_WAIT) step("fetch_wait", 0, OPX, C_FW);
    step("fetch_late", 1, OPX, C_FR); step("dec_lw", 0, 6'h23, C_DEC);
    step("memadr_lw", 0, OPX, C_MEMADR);
    repeat (MAX_WAIT) step("memrd_wait", 0, OPX, C_MEMRD);
    step("memrd_late", 1, OPX, C_MEMRD); step("memwb", 0, OPX, C_MEMWB);

    // store that never completes times out into FAULT, which stays sticky
    step("fetch", 1, OPX, C_FR); step("dec_sw", 0, 6'h2B, C_DEC);
    step("memadr_sw", 0, OPX, C_MEMADR);
    repeat (MAX_WAIT + 1) step("memwr_stall", 0, OPX, C_MEMWR);
    repeat (3) step("fault_wr", 1, 6'h00, C_FAULT);

    // fetch timeout straight out of reset
    do_reset();
    repeat (MAX_WAIT) step("fetch_stall", 0, OPX, C_FW);
    step("fetch_last", 0, OPX, C_FW);
    repeat (3) step("fault_fetch", 0, OPX, C_FAULT);

    // hlt: counters freeze once HALT is reached
    do_reset();
    step("fetch", 1, OPX, C_FR); step("dec_hlt", 0, 6'h3F, C_DEC);
    repeat (3) step("halt", 1, 6'h00, C_HALT);

    // illegal opcode
    do_reset();
    step("fetch", 1, OPX, C_FR); step("dec_ill", 0, 6'h11, C_DEC);
    repeat (2) step("fault_ill", 1, 6'h00, C_FAULT);

    // reset during a load aborts it; no MEMWB afterwards
    do_reset();
    step("fetch", 1, OPX, C_FR); step("dec_lw", 0, 6'h23, C_DEC);
    step("memadr_lw", 0, OPX, C_MEMADR); step("memrd_wait", 0, OPX, C_MEMRD);
    do_reset();
    step("fetch_after_abort", 1, OPX, C_FR);

    // bne
    step("dec_bne", 0, 6'h05, C_DEC);
`ifdef MULTICYCLE_CONTROL_BNE_EN
    step("bne", 0, 6'h04, C_BNE);
    step("fetch", 0, OPX, C_FW);
`else
    repeat (2) step("fault_bne", 1, OPX, C_FAULT);
`endif

    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
